// File: rtl/tdm_demux16_if.sv
// Bundle between the TDM deserializer and its environment (frame control, mux select, word output).
// Latency: none, wires only.
// Backpressure: din_valid low stalls capture; the word consumer cannot push back.
interface tdm_demux16_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic             start;
  logic             abort;
  logic             din;
  logic             din_valid;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             busy;

  // Environment side: issues frame control and feeds the serial bit back from the mux.
  modport master (
    output start, abort, din, din_valid,
    input  sel, data_out, out_valid, busy
  );

  // Deserializer side.
  modport slave (
    input  start, abort, din, din_valid,
    output sel, data_out, out_valid, busy
  );
endinterface

// File: rtl/tdm_demux16.sv
// 1:WIDTH TDM deserializer: steps the upstream mux select and reassembles one bit per select value.
// Latency: out_valid WIDTH+1 cycles after the start cycle when din_valid stays high.
// Backpressure: din_valid low holds sel and shadow; there is no timeout; the output is a one-cycle pulse.
module tdm_demux16 #(
  parameter int WIDTH      = 16,
  parameter int SEL_W      = 4,   // 2**SEL_W must equal WIDTH
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux16_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ov_q, ov_d;

  // State and datapath registers; reset mid-frame drops partial data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      ov_q     <= ov_d;
    end
  end

  // Next-state: abort beats capture and wrap; the last bit goes straight into data_out,
  // bypassing shadow, so the word is available the cycle after its final capture.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    ov_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (bus.start && !bus.abort) state_d = SCAN;
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (bus.din_valid) begin
          shadow_d[sel_q] = bus.din;
          if (sel_q == SEL_LAST) begin
            data_d = {bus.din, shadow_q[WIDTH-2:0]};
            ov_d   = 1'b1;
            sel_d  = '0;
            if (!CONTINUOUS) state_d = IDLE;
          end else begin
            sel_d = sel_q + SEL_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Every output comes straight from a flop so the mux select never glitches.
  assign bus.sel       = sel_q;
  assign bus.data_out  = data_q;
  assign bus.out_valid = ov_q;
  assign bus.busy      = (state_q == SCAN);

endmodule
